aurora_crc_drop_fifo: RTL and testbench

Store-and-forward frame buffer downstream of the Aurora dual-CRC16 checker. It accepts the checker's non-backpressurable stream and holds each frame until the checker's end-of-frame verdict. Frames with a good CRC, a correct length and no overflow are committed and forwarded on a backpressured AXI4-Stream master. Any other frame is rewound out of the buffer and never reaches the consumer.

---
 rtl/aurora_crc_drop_fifo_if.sv | 18 +
 rtl/aurora_crc_drop_fifo.sv | 169 ++++++++++++++++
 tb/tb_aurora_crc_drop_fifo.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aurora_crc_drop_fifo_if.sv
// AXI4-Stream beat bundle shared by the checker-facing input and the
// consumer-facing output of the CRC drop FIFO.
//   tdata/tkeep/tuser/tlast/tvalid : beat payload and valid (master -> slave)
//   tready                         : consumer ready (slave -> master)
interface aurora_crc_drop_fifo_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned KEEP_W = DATA_W / 8;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tuser;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/aurora_crc_drop_fifo.sv
// Store-and-forward frame buffer behind the Aurora dual-CRC16 checker.
// Beats are written speculatively; the tlast verdict either commits the frame
// (making it readable) or rewinds the write pointer so it never leaves.
//   s_axis_aclk, aresetn     : clock, synchronous active-low reset
//   s_axis (slave)           : unstoppable beat stream from the checker
//   s_axis_crc_valid/_pass_fail_n/_length_err : verdict on the tlast beat
//   m_axis (master)          : committed frames, backpressured by tready
//   frame_good/frame_drop_*  : one-cycle verdict pulses
//   good_count/drop_count    : wrapping frame counters
//   fill_level               : committed entries not yet consumed
module aurora_crc_drop_fifo #(
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic                   s_axis_aclk,
  input  logic                   aresetn,
  aurora_crc_drop_fifo_if.slave  s_axis,
  input  logic                   s_axis_crc_valid,
  input  logic                   s_axis_crc_pass_fail_n,
  input  logic                   s_axis_length_err,
  aurora_crc_drop_fifo_if.master m_axis,
  output logic                   frame_good,
  output logic                   frame_drop_crc,
  output logic                   frame_drop_len,
  output logic                   frame_drop_ovf,
  output logic [15:0]            good_count,
  output logic [15:0]            drop_count,
  output logic [DEPTH_LOG2:0]    fill_level
);
  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned OB_W  = 2;

  typedef struct packed {
    logic        last;
    logic        user;
    logic [3:0]  keep;
    logic [31:0] data;
  } entry_t;

  entry_t mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, wr_ptr_n, wr_adv;
  logic [PTR_W-1:0] wr_commit, wr_commit_n;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_n;
  logic [PTR_W-1:0] fill_n;
  logic             ovf, ovf_n, ovf_hit;
  logic             wr_en, full;
  logic             good_n, drop_crc_n, drop_len_n, drop_ovf_n;

  entry_t           wr_entry, rd_entry;
  entry_t           ob0, ob1, ob0_n, ob1_n;
  logic [OB_W-1:0]  ob_cnt, ob_cnt_n;
  logic             m_valid;
  logic             avail, pop, rd_issue;

  // The checker cannot be stalled.
  assign s_axis.tready = 1'b1;

  assign full     = (wr_ptr - rd_ptr) == PTR_W'(DEPTH);
  assign wr_entry = '{last: s_axis.tlast, user: s_axis.tuser,
                      keep: s_axis.tkeep, data: s_axis.tdata};

  // Write side: speculative append, sticky overflow, verdict on tlast.
  always_comb begin
    wr_en       = s_axis.tvalid && !full && !ovf;
    ovf_hit     = ovf || (s_axis.tvalid && !wr_en);
    wr_adv      = wr_ptr + PTR_W'(wr_en);
    wr_ptr_n    = wr_adv;
    wr_commit_n = wr_commit;
    ovf_n       = ovf_hit;
    good_n      = 1'b0;
    drop_crc_n  = 1'b0;
    drop_len_n  = 1'b0;
    drop_ovf_n  = 1'b0;
    if (s_axis.tvalid && s_axis.tlast) begin
      ovf_n = 1'b0;
      if (ovf_hit)                                          drop_ovf_n = 1'b1;
      else if (s_axis_length_err)                           drop_len_n = 1'b1;
      else if (!s_axis_crc_valid || !s_axis_crc_pass_fail_n) drop_crc_n = 1'b1;
      else                                                  good_n     = 1'b1;
      // Rewind discards the whole frame, including this beat.
      if (good_n) wr_commit_n = wr_adv;
      else        wr_ptr_n    = wr_commit;
    end
  end

  // Read side: RAM read lands directly in the 2-entry output stage.
  assign rd_entry = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign pop      = m_valid && m_axis.tready;
  assign avail    = rd_ptr != wr_commit;
  assign rd_issue = avail && ((ob_cnt != OB_W'(2)) || pop);

  always_comb begin
    rd_ptr_n = rd_ptr + PTR_W'(rd_issue);
    ob0_n    = ob0;
    ob1_n    = ob1;
    ob_cnt_n = ob_cnt;
    case ({rd_issue, pop})
      2'b01: begin
        ob0_n    = ob1;
        ob_cnt_n = ob_cnt - OB_W'(1);
      end
      2'b10: begin
        if (ob_cnt == OB_W'(0)) ob0_n = rd_entry;
        else                    ob1_n = rd_entry;
        ob_cnt_n = ob_cnt + OB_W'(1);
      end
      2'b11: begin
        if (ob_cnt == OB_W'(1)) begin
          ob0_n = rd_entry;
        end else begin
          ob0_n = ob1;
          ob1_n = rd_entry;
        end
      end
      default: ;
    endcase
    fill_n = (wr_commit_n - rd_ptr_n) + PTR_W'(ob_cnt_n);
  end

  // Buffer storage (no reset needed; pointers gate visibility).
  always_ff @(posedge s_axis_aclk) begin
    if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_entry;
  end

  // Pointers, flags, output stage, pulses and counters.
  always_ff @(posedge s_axis_aclk) begin
    if (!aresetn) begin
      wr_ptr         <= '0;
      wr_commit      <= '0;
      rd_ptr         <= '0;
      ovf            <= 1'b0;
      ob0            <= '0;
      ob1            <= '0;
      ob_cnt         <= '0;
      m_valid        <= 1'b0;
      frame_good     <= 1'b0;
      frame_drop_crc <= 1'b0;
      frame_drop_len <= 1'b0;
      frame_drop_ovf <= 1'b0;
      good_count     <= '0;
      drop_count     <= '0;
      fill_level     <= '0;
    end else begin
      wr_ptr         <= wr_ptr_n;
      wr_commit      <= wr_commit_n;
      rd_ptr         <= rd_ptr_n;
      ovf            <= ovf_n;
      ob0            <= ob0_n;
      ob1            <= ob1_n;
      ob_cnt         <= ob_cnt_n;
      m_valid        <= ob_cnt_n != OB_W'(0);
      frame_good     <= good_n;
      frame_drop_crc <= drop_crc_n;
      frame_drop_len <= drop_len_n;
      frame_drop_ovf <= drop_ovf_n;
      good_count     <= good_count + CNT_W'(good_n);
      drop_count     <= drop_count + CNT_W'(drop_crc_n | drop_len_n | drop_ovf_n);
      fill_level     <= fill_n;
    end
  end

  assign m_axis.tvalid = m_valid;
  assign m_axis.tdata  = ob0.data;
  assign m_axis.tkeep  = ob0.keep;
  assign m_axis.tuser  = ob0.user;
  assign m_axis.tlast  = ob0.last;
endmodule

// File: tb/tb_aurora_crc_drop_fifo.sv
// Directed and constrained-random bench for aurora_crc_drop_fifo (depth 16).
module tb_aurora_crc_drop_fifo;
  localparam int unsigned DL = 4;
  localparam int unsigned PW = DL + 1;

  logic clk = 1'b0;
  logic aresetn;
  logic crc_valid, crc_pass, len_err;
  logic frame_good, drop_crc, drop_len, drop_ovf;
  logic [15:0] good_count, drop_count;
  logic [PW-1:0] fill_level;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hold_err = 0;
  logic [37:0] got_q[$];
  int got_cyc[$];
  logic prev_stall = 1'b0;
  logic [37:0] prev_beat, mon_beat;
  bit rand_rdy = 0;

  aurora_crc_drop_fifo_if s_if();
  aurora_crc_drop_fifo_if m_if();

  aurora_crc_drop_fifo #(.DEPTH_LOG2(DL)) dut (
    .s_axis_aclk(clk), .aresetn(aresetn), .s_axis(s_if),
    .s_axis_crc_valid(crc_valid), .s_axis_crc_pass_fail_n(crc_pass),
    .s_axis_length_err(len_err), .m_axis(m_if),
    .frame_good(frame_good), .frame_drop_crc(drop_crc),
    .frame_drop_len(drop_len), .frame_drop_ovf(drop_ovf),
    .good_count(good_count), .drop_count(drop_count), .fill_level(fill_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Output capture and hold-while-stalled tracking.
  always @(negedge clk) begin
    mon_beat = {m_if.tlast, m_if.tuser, m_if.tkeep, m_if.tdata};
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_if.tvalid || mon_beat !== prev_beat)) hold_err++;
      if (m_if.tvalid && m_if.tready) begin
        got_q.push_back(mon_beat);
        got_cyc.push_back(cyc);
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_beat  = mon_beat;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) m_if.tready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle();
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    crc_valid   = 1'b0;
    crc_pass    = 1'b0;
    len_err     = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic u,
                           input logic last, input logic cv, input logic cp, input logic le);
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tuser  = u;
    s_if.tlast  = last;
    crc_valid   = cv;
    crc_pass    = cp;
    len_err     = le;
    tick();
    idle();
  endtask

  task automatic send_frame(input int n, input logic [31:0] d0, input logic [31:0] step,
                            input logic cv, input logic cp, input logic le);
    for (int i = 0; i < n; i++) begin
      send_beat(d0 + 32'(i) * step, 4'hF, 1'b0, i == n - 1,
                cv && (i == n - 1), cp && (i == n - 1), le && (i == n - 1));
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    m_if.tready = 1'b0;
    s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = 1'b0;
    idle();
    tick(); tick();
    tests++;
    if (m_if.tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b want 0", m_if.tvalid); end
    tests++;
    if (fill_level !== '0) begin fails++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
    tests++;
    if ({good_count, drop_count} !== 32'h0) begin fails++; $display("FAIL reset_counts: got %0d/%0d want 0/0", good_count, drop_count); end
    tests++;
    if ({frame_good, drop_crc, drop_len, drop_ovf} !== 4'b0000) begin fails++; $display("FAIL reset_pulses: got %b want 0000", {frame_good, drop_crc, drop_len, drop_ovf}); end
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_good_frame();
    int base;
    logic [37:0] e;
    m_if.tready = 1'b1;
    base = got_q.size();
    send_frame(4, 32'h11111111, 32'h11111111, 1'b1, 1'b1, 1'b0);
    tests++;
    if ({frame_good, drop_crc, drop_len, drop_ovf} !== 4'b1000) begin fails++; $display("FAIL good_pulse: got %b want 1000", {frame_good, drop_crc, drop_len, drop_ovf}); end
    tests++;
    if (good_count !== 16'd1) begin fails++; $display("FAIL good_count: got %0d want 1", good_count); end
    tests++;
    if (m_if.tvalid !== 1'b0) begin fails++; $display("FAIL good_latency1: tvalid got %b want 0", m_if.tvalid); end
    tick();
    tests++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'h11111111) begin fails++; $display("FAIL good_latency2: tvalid %b data %h want 1 11111111", m_if.tvalid, m_if.tdata); end
    tests++;
    if (frame_good !== 1'b0) begin fails++; $display("FAIL good_pulse_width: got %b want 0", frame_good); end
    repeat (6) tick();
    tests++;
    if (got_q.size() - base !== 4) begin
      fails++; $display("FAIL good_beats: got %0d beats want 4", got_q.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        e = {1'(i == 3), 1'b0, 4'hF, 32'h11111111 * 32'(i + 1)};
        tests++;
        if (got_q[base + i] !== e) begin fails++; $display("FAIL good_beat%0d: got %h want %h", i, got_q[base + i], e); end
      end
    end
  endtask

  task automatic test_crc_drop();
    int base;
    m_if.tready = 1'b1;
    base = got_q.size();
    send_frame(4, 32'h11111111, 32'h11111111, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({frame_good, drop_crc, drop_len, drop_ovf} !== 4'b0100) begin fails++; $display("FAIL crc_pulse: got %b want 0100", {frame_good, drop_crc, drop_len, drop_ovf}); end
    tests++;
    if (drop_count !== 16'd1 || good_count !== 16'd1) begin fails++; $display("FAIL crc_counts: got %0d/%0d want 1/1", good_count, drop_count); end
    repeat (6) tick();
    tests++;
    if (got_q.size() !== base) begin fails++; $display("FAIL crc_leak: got %0d beats want 0", got_q.size() - base); end
    tests++;
    if (fill_level !== '0) begin fails++; $display("FAIL crc_fill: got %0d want 0", fill_level); end
  endtask

  task automatic test_back_to_back();
    int base;
    logic [37:0] e;
    m_if.tready = 1'b0;
    base = got_q.size();
    send_frame(3, 32'hA0000001, 32'h1, 1'b1, 1'b1, 1'b0);
    send_frame(2, 32'hB0000001, 32'h1, 1'b1, 1'b1, 1'b1);
    tests++;
    if ({frame_good, drop_crc, drop_len, drop_ovf} !== 4'b0010) begin fails++; $display("FAIL b2b_len_pulse: got %b want 0010", {frame_good, drop_crc, drop_len, drop_ovf}); end
    send_frame(3, 32'hC0000001, 32'h1, 1'b1, 1'b1, 1'b0);
    tick();
    m_if.tready = 1'b1;
    repeat (10) tick();
    tests++;
    if (got_q.size() - base !== 6) begin
      fails++; $display("FAIL b2b_beats: got %0d beats want 6", got_q.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        e = (i < 3) ? {1'(i == 2), 1'b0, 4'hF, 32'hA0000001 + 32'(i)}
                    : {1'(i == 5), 1'b0, 4'hF, 32'hC0000001 + 32'(i - 3)};
        tests++;
        if (got_q[base + i] !== e) begin fails++; $display("FAIL b2b_beat%0d: got %h want %h", i, got_q[base + i], e); end
      end
      tests++;
      if (got_cyc[base + 5] - got_cyc[base] !== 5) begin fails++; $display("FAIL b2b_contiguous: span %0d cycles want 5", got_cyc[base + 5] - got_cyc[base]); end
    end
    tests++;
    if (good_count !== 16'd3 || drop_count !== 16'd2) begin fails++; $display("FAIL b2b_counts: got %0d/%0d want 3/2", good_count, drop_count); end
  endtask

  task automatic test_overflow();
    int base;
    logic [37:0] e;
    m_if.tready = 1'b0;
    base = got_q.size();
    send_frame(20, 32'h50000000, 32'h1, 1'b1, 1'b1, 1'b1);
    tests++;
    if ({frame_good, drop_crc, drop_len, drop_ovf} !== 4'b0001) begin fails++; $display("FAIL ovf_pulse: got %b want 0001", {frame_good, drop_crc, drop_len, drop_ovf}); end
    tests++;
    if (fill_level !== '0) begin fails++; $display("FAIL ovf_fill: got %0d want 0", fill_level); end
    send_frame(16, 32'h60000000, 32'h1, 1'b1, 1'b1, 1'b0);
    tests++;
    if ({frame_good, drop_crc, drop_len, drop_ovf} !== 4'b1000) begin fails++; $display("FAIL full16_pulse: got %b want 1000", {frame_good, drop_crc, drop_len, drop_ovf}); end
    repeat (3) tick();
    tests++;
    if (fill_level !== PW'(16)) begin fails++; $display("FAIL full16_fill: got %0d want 16", fill_level); end
    m_if.tready = 1'b1;
    repeat (20) tick();
    tests++;
    if (got_q.size() - base !== 16) begin
      fails++; $display("FAIL full16_beats: got %0d beats want 16", got_q.size() - base);
    end else begin
      for (int i = 0; i < 16; i++) begin
        e = {1'(i == 15), 1'b0, 4'hF, 32'h60000000 + 32'(i)};
        tests++;
        if (got_q[base + i] !== e) begin fails++; $display("FAIL full16_beat%0d: got %h want %h", i, got_q[base + i], e); end
      end
    end
    tests++;
    if (fill_level !== '0 || good_count !== 16'd4 || drop_count !== 16'd3) begin fails++; $display("FAIL full16_after: fill %0d counts %0d/%0d want 0 4/3", fill_level, good_count, drop_count); end
  endtask

  task automatic test_random();
    int base, ng, nd, len, v, mism;
    logic [37:0] exp_q[$];
    logic [37:0] frm[$];
    logic [37:0] b;
    ng = 4; nd = 3;
    base = got_q.size();
    rand_rdy = 1;
    for (int f = 0; f < 100; f++) begin
      for (int w = 0; w < 300 && (fill_level != '0 || m_if.tvalid); w++) tick();
      tests++;
      if (fill_level != '0 || m_if.tvalid) begin fails++; $display("FAIL rand_drain%0d: fill %0d still busy", f, fill_level); end
      len = $urandom_range(1, 8);
      v = $urandom_range(0, 3);
      frm.delete();
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        b = {1'(i == len - 1), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 32'($urandom)};
        frm.push_back(b);
        send_beat(b[31:0], b[35:32], b[36], b[37],
                  (i == len - 1) && (v != 2), (i == len - 1) && (v != 1), (i == len - 1) && (v == 3));
      end
      if (v == 0) begin
        ng++;
        foreach (frm[j]) exp_q.push_back(frm[j]);
      end else begin
        nd++;
      end
    end
    for (int w = 0; w < 300 && (fill_level != '0 || m_if.tvalid); w++) tick();
    rand_rdy = 0;
    m_if.tready = 1'b1;
    tick();
    tests++;
    if (got_q.size() - base !== exp_q.size()) begin fails++; $display("FAIL rand_beats: got %0d want %0d", got_q.size() - base, exp_q.size()); end
    mism = 0;
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      if (got_q[base + i] !== exp_q[i]) mism++;
    end
    tests++;
    if (mism != 0) begin fails++; $display("FAIL rand_data: got %0d mismatched beats want 0", mism); end
    tests++;
    if (good_count !== 16'(ng) || drop_count !== 16'(nd)) begin fails++; $display("FAIL rand_counts: got %0d/%0d want %0d/%0d", good_count, drop_count, ng, nd); end
    tests++;
    if (16'(good_count + drop_count - 16'd7) !== 16'd100) begin fails++; $display("FAIL rand_total: got %0d want 100", good_count + drop_count - 16'd7); end
    tests++;
    if (hold_err !== 0) begin fails++; $display("FAIL rand_hold: got %0d unstable stalls want 0", hold_err); end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    logic [37:0] e;
    m_if.tready = 1'b0;
    send_frame(3, 32'h70000000, 32'h1, 1'b1, 1'b1, 1'b0);
    tick(); tick();
    tests++;
    if (m_if.tvalid !== 1'b1) begin fails++; $display("FAIL rst_pending: tvalid got %b want 1", m_if.tvalid); end
    send_beat(32'h80000000, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(32'h80000001, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    aresetn = 1'b0;
    send_beat(32'h80000002, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tests++;
    if (m_if.tvalid !== 1'b0 || fill_level !== '0) begin fails++; $display("FAIL rst_mid_out: tvalid %b fill %0d want 0 0", m_if.tvalid, fill_level); end
    tests++;
    if ({good_count, drop_count} !== 32'h0 || {frame_good, drop_crc, drop_len, drop_ovf} !== 4'b0000) begin fails++; $display("FAIL rst_mid_state: counts %0d/%0d pulses %b want 0/0 0000", good_count, drop_count, {frame_good, drop_crc, drop_len, drop_ovf}); end
    aresetn = 1'b1;
    send_frame(2, 32'h80000003, 32'h1, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({frame_good, drop_crc, drop_len, drop_ovf} !== 4'b0100 || drop_count !== 16'd1) begin fails++; $display("FAIL rst_tail: pulses %b drops %0d want 0100 1", {frame_good, drop_crc, drop_len, drop_ovf}, drop_count); end
    m_if.tready = 1'b1;
    base = got_q.size();
    send_frame(3, 32'h90000000, 32'h1, 1'b1, 1'b1, 1'b0);
    repeat (8) tick();
    tests++;
    if (got_q.size() - base !== 3) begin
      fails++; $display("FAIL rst_after_beats: got %0d want 3", got_q.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        e = {1'(i == 2), 1'b0, 4'hF, 32'h90000000 + 32'(i)};
        tests++;
        if (got_q[base + i] !== e) begin fails++; $display("FAIL rst_after_beat%0d: got %h want %h", i, got_q[base + i], e); end
      end
    end
    tests++;
    if (good_count !== 16'd1) begin fails++; $display("FAIL rst_after_count: got %0d want 1", good_count); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_crc_drop();
    test_back_to_back();
    test_overflow();
    test_random();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
